// File: rtl/qr_back_substitution_if.sv
// Handshake and data bundle between the QR factorisation stage, the back-substitution
// solver and whatever consumes the solution.
interface qr_back_substitution_if #(
  parameter int unsigned M = 3,
  parameter int unsigned N = 3
) ();
  logic in_valid;
  logic in_ready;
  real  q [M][N];
  real  r [N][N];
  real  b [M];
  logic out_valid;
  real  x [N];
  logic singular;

  modport master (
    output in_valid, q, r, b,
    input  in_ready, out_valid, x, singular
  );

  modport slave (
    input  in_valid, q, r, b,
    output in_ready, out_valid, x, singular
  );
endinterface

// File: rtl/qr_back_substitution.sv
// Least-squares solve from QR factors: y = Q^T b, then R x = y by back substitution.
// One multiply-accumulate row per clock; pivots below EPS are forced to zero and flagged.
module qr_back_substitution #(
  parameter int unsigned M   = 3,
  parameter int unsigned N   = 3,
  parameter real         EPS = 1.0e-12
) (
  input logic                   clk,
  input logic                   rst_n,
  qr_back_substitution_if.slave bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IdxLast = IW'(N - 1);
  localparam logic [IW-1:0] IdxOne  = IW'(1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StProj  = 2'd1;
  localparam logic [1:0] StSolve = 2'd2;

  if (M < N) begin : g_bad_dims
    $fatal(1, "qr_back_substitution: M must be >= N");
  end

  logic [1:0]    state_q;
  logic [IW-1:0] idx_q;
  logic          singular_q;
  logic          out_valid_q;

  real q_q [M][N];
  real r_q [N][N];
  real b_q [M];
  real y_q [N];
  real x_q [N];

  real proj_sum;
  real solve_sum;
  real pivot;
  real pivot_abs;

  always_comb begin
    proj_sum = 0.0;
    for (int unsigned i = 0; i < M; i++) begin
      proj_sum += q_q[i][idx_q] * b_q[i];
    end
  end

  // Only columns right of the pivot contribute; those x entries were written earlier this solve.
  always_comb begin
    solve_sum = y_q[idx_q];
    for (int unsigned k = 0; k < N; k++) begin
      if (k > 32'(idx_q)) begin
        solve_sum -= r_q[idx_q][k] * x_q[k];
      end
    end
    pivot     = r_q[idx_q][idx_q];
    pivot_abs = (pivot < 0.0) ? -pivot : pivot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      singular_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < M; i++) begin
        b_q[i] <= 0.0;
        for (int unsigned j = 0; j < N; j++) q_q[i][j] <= 0.0;
      end
      for (int unsigned i = 0; i < N; i++) begin
        y_q[i] <= 0.0;
        x_q[i] <= 0.0;
        for (int unsigned j = 0; j < N; j++) r_q[i][j] <= 0.0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            for (int unsigned i = 0; i < M; i++) begin
              b_q[i] <= bus.b[i];
              for (int unsigned j = 0; j < N; j++) q_q[i][j] <= bus.q[i][j];
            end
            for (int unsigned i = 0; i < N; i++) begin
              for (int unsigned j = 0; j < N; j++) r_q[i][j] <= bus.r[i][j];
            end
            singular_q <= 1'b0;
            idx_q      <= '0;
            state_q    <= StProj;
          end
        end
        StProj: begin
          y_q[idx_q] <= proj_sum;
          if (idx_q == IdxLast) begin
            state_q <= StSolve;
          end else begin
            idx_q <= idx_q + IdxOne;
          end
        end
        StSolve: begin
          // Skip the divide entirely on a vanishing pivot so no inf/NaN can appear.
          if (pivot_abs >= EPS) begin
            x_q[idx_q] <= solve_sum / pivot;
          end else begin
            x_q[idx_q] <= 0.0;
            singular_q <= 1'b1;
          end
          if (idx_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            idx_q <= idx_q - IdxOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.singular  = singular_q;
  assign bus.x         = x_q;
endmodule

// File: tb/tb_qr_back_substitution.sv
// Directed bench for qr_back_substitution: stimulus pushes expected solutions into a
// scoreboard, and a negedge monitor pops and compares on every out_valid pulse.
module tb_qr_back_substitution;
  localparam int unsigned M = 3;
  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qr_back_substitution_if #(.M(M), .N(N)) bus ();

  qr_back_substitution #(.M(M), .N(N), .EPS(1.0e-12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string name;
    real   x0;
    real   x1;
    real   x2;
    logic  sing;
    real   tol;
  } exp_t;

  exp_t sb[$];
  real  ga [3][3];

  function automatic real fabs(real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Written as !(d <= tol) so that a NaN result also fails.
  task automatic chk_real(string nm, real act, real exp, real tol);
    n_tests++;
    if (!(fabs(act - exp) <= tol)) begin
      n_fail++;
      $display("FAIL %s: got %0.12f expected %0.12f", nm, act, exp);
    end
  endtask

  task automatic chk_bit(string nm, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(string nm, real x0, real x1, real x2, logic sing, real tol);
    exp_t e;
    e.name = nm; e.x0 = x0; e.x1 = x1; e.x2 = x2; e.sing = sing; e.tol = tol;
    sb.push_back(e);
  endtask

  task automatic set_q(real a00, real a01, real a02, real a10, real a11, real a12,
                       real a20, real a21, real a22);
    bus.q[0][0] = a00; bus.q[0][1] = a01; bus.q[0][2] = a02;
    bus.q[1][0] = a10; bus.q[1][1] = a11; bus.q[1][2] = a12;
    bus.q[2][0] = a20; bus.q[2][1] = a21; bus.q[2][2] = a22;
  endtask

  task automatic set_r(real a00, real a01, real a02, real a10, real a11, real a12,
                       real a20, real a21, real a22);
    bus.r[0][0] = a00; bus.r[0][1] = a01; bus.r[0][2] = a02;
    bus.r[1][0] = a10; bus.r[1][1] = a11; bus.r[1][2] = a12;
    bus.r[2][0] = a20; bus.r[2][1] = a21; bus.r[2][2] = a22;
  endtask

  task automatic set_b(real b0, real b1, real b2);
    bus.b[0] = b0; bus.b[1] = b1; bus.b[2] = b2;
  endtask

  task automatic set_a(real a00, real a01, real a02, real a10, real a11, real a12,
                       real a20, real a21, real a22);
    ga[0][0] = a00; ga[0][1] = a01; ga[0][2] = a02;
    ga[1][0] = a10; ga[1][1] = a11; ga[1][2] = a12;
    ga[2][0] = a20; ga[2][1] = a21; ga[2][2] = a22;
  endtask

  // Stand-in for the upstream stage: classical Gram-Schmidt of ga onto bus.q / bus.r.
  task automatic qr_from_a();
    real v [3];
    real nrm;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        bus.q[i][j] = 0.0;
        bus.r[i][j] = 0.0;
      end
    end
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) v[i] = ga[i][j];
      for (int k = 0; k < j; k++) begin
        real d;
        d = 0.0;
        for (int i = 0; i < 3; i++) d += bus.q[i][k] * ga[i][j];
        bus.r[k][j] = d;
        for (int i = 0; i < 3; i++) v[i] -= d * bus.q[i][k];
      end
      nrm = $sqrt(v[0] * v[0] + v[1] * v[1] + v[2] * v[2]);
      bus.r[j][j] = nrm;
      for (int i = 0; i < 3; i++) bus.q[i][j] = (nrm > 1.0e-300) ? v[i] / nrm : 0.0;
    end
  endtask

  // Called just after the capture edge; counts edges to out_valid and checks in_ready meanwhile.
  task automatic wait_out(string nm, int exp_lat);
    int lat;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
      chk_bit({nm, ".in_ready_busy"}, bus.in_ready, 1'b0);
    end
    chk_int({nm, ".latency"}, lat, exp_lat);
    chk_bit({nm, ".in_ready_done"}, bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk_bit({nm, ".out_valid_pulse"}, bus.out_valid, 1'b0);
  endtask

  task automatic run_solve(string nm);
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_out(nm, 6);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        chk_real({e.name, ".x0"}, bus.x[0], e.x0, e.tol);
        chk_real({e.name, ".x1"}, bus.x[1], e.x1, e.tol);
        chk_real({e.name, ".x2"}, bus.x[2], e.x2, e.tol);
        chk_bit({e.name, ".singular"}, bus.singular, e.sing);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    set_q(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_r(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("reset.in_ready", bus.in_ready, 1'b1);
    chk_bit("reset.out_valid", bus.out_valid, 1'b0);
    chk_bit("reset.singular", bus.singular, 1'b0);
    chk_real("reset.x0", bus.x[0], 0.0, 0.0);
    chk_real("reset.x2", bus.x[2], 0.0, 0.0);

    // Identity Q, x = [1, 1, 2].
    set_q(1, 0, 0, 0, 1, 0, 0, 0, 1);
    set_r(2, 1, 1, 0, 3, 2, 0, 0, 4);
    set_b(5, 7, 8);
    push_exp("ident", 1.0, 1.0, 2.0, 1'b0, 1.0e-9);
    run_solve("ident");

    // Permuted Q projects b = [7, 5, 8] to y = [5, 7, 8].
    set_q(0, 1, 0, 1, 0, 0, 0, 0, 1);
    set_b(7, 5, 8);
    push_exp("perm", 1.0, 1.0, 2.0, 1'b0, 1.0e-9);
    run_solve("perm");

    // Pulses while busy are ignored; the pulse held through edge 7 is taken.
    set_q(1, 0, 0, 0, 1, 0, 0, 0, 1);
    set_b(5, 7, 8);
    push_exp("busy_first", 1.0, 1.0, 2.0, 1'b0, 1.0e-9);
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk);              // E0
    #1;
    bus.in_valid = 1'b0;
    set_b(4, 3, 4);
    @(posedge clk);              // E1
    #1;
    bus.in_valid = 1'b1;
    @(posedge clk);              // E2
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);   // E5
    #1;
    bus.in_valid = 1'b1;
    push_exp("busy_second", 4.0 / 3.0, 1.0 / 3.0, 1.0, 1'b0, 1.0e-9);
    @(posedge clk);              // E6
    #1;
    chk_bit("busy_first.out_valid_e6", bus.out_valid, 1'b1);
    @(posedge clk);              // E7
    #1;
    bus.in_valid = 1'b0;
    wait_out("busy_second", 6);

    // Zero pivot on R[2][2].
    set_r(2, 1, 1, 0, 3, 2, 0, 0, 0);
    set_b(5, 7, 8);
    push_exp("zero_pivot", 4.0 / 3.0, 7.0 / 3.0, 0.0, 1'b1, 1.0e-9);
    run_solve("zero_pivot");

    // Reset during SOLVE aborts the solve with no out_valid.
    set_r(2, 1, 1, 0, 3, 2, 0, 0, 4);
    @(negedge clk);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_real("abort.x0", bus.x[0], 0.0, 0.0);
    chk_real("abort.x1", bus.x[1], 0.0, 0.0);
    chk_real("abort.x2", bus.x[2], 0.0, 0.0);
    chk_bit("abort.singular", bus.singular, 1'b0);
    chk_bit("abort.in_ready", bus.in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_bit("abort.no_out_valid", bus.out_valid, 1'b0);
    push_exp("after_abort", 1.0, 1.0, 2.0, 1'b0, 1.0e-9);
    run_solve("after_abort");

    // Factors from the QR stage: rank-deficient A, then a well-conditioned A.
    set_a(1, 2, 3, 4, 5, 6, 7, 8, 9);
    qr_from_a();
    set_b(1, 4, 7);
    push_exp("qr_rankdef", 1.0, 0.0, 0.0, 1'b1, 1.0e-6);
    run_solve("qr_rankdef");

    set_a(2, 1, 1, 1, 3, 2, 1, 0, 0);
    qr_from_a();
    set_b(7, 13, 1);
    push_exp("qr_full", 1.0, 2.0, 3.0, 1'b0, 1.0e-6);
    run_solve("qr_full");

    repeat (3) @(posedge clk);
    #1;
    chk_int("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qr_back_substitution.md
Name: qr_back_substitution

Overview:
- Downstream stage of the QR decomposition block. Consumes its Q (MxN) and R (NxN, upper triangular) outputs plus a right-hand-side vector b (M).
- Produces the least-squares solution x (N) of A·x = b by computing y = Qᵀ·b and then solving R·x = y by back substitution.
- Arithmetic uses `real`, matching the upstream stage. The block is a simulation/algorithm model with a cycle-accurate control path: one multiply-accumulate row per cycle.

Parameters:
- M, 3, rows of Q and length of b; M >= N is required (static check, $fatal otherwise).
- N, 3, columns of Q, size of R, length of x.
- EPS, 1.0e-12, pivot threshold; |R[i][i]| < EPS is treated as zero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  Q, R and b are valid this cycle; accepted only when in_ready=1.
- in_ready  out  1  high in IDLE only.
- Q  in  real[M][N]  orthonormal-column factor from the upstream stage.
- R  in  real[N][N]  upper-triangular factor; entries below the diagonal are ignored.
- b  in  real[M]  right-hand side.
- out_valid  out  1  one-cycle pulse; x and singular are valid while it is high.
- x  out  real[N]  solution vector.
- singular  out  1  at least one pivot was below EPS during this solve.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0, singular=0.
  - x, the internal y and the captured Q/R/b copies all = 0.0.
- States: IDLE -> PROJ -> SOLVE -> IDLE.
- IDLE:
  - On an edge with in_valid=1, capture Q, R and b into internal registers, clear singular, clear j.
  - Go to PROJ and drop in_ready.
  - Input ports are not sampled again until the block returns to IDLE.
- PROJ:
  - One edge per j = 0..N-1: y[j] <= Σ_{i=0..M-1} Q[i][j]·b[i].
  - After j=N-1, set i=N-1 and go to SOLVE.
- SOLVE:
  - One edge per i = N-1 down to 0: s = y[i] − Σ_{k=i+1..N-1} R[i][k]·x[k], using x values already written this solve.
  - If |R[i][i]| >= EPS: x[i] <= s / R[i][i].
  - Else: x[i] <= 0.0 and singular <= 1 (sticky until the next capture).
  - At i=0: out_valid <= 1, state <= IDLE.
- Timing:
  - Capture at edge E0; out_valid is high for exactly the cycle after edge E2N (2N edges of latency; 6 for N=3).
  - in_ready rises at E2N, the same edge out_valid rises, so the earliest next capture is E2N+1. Throughput is one solve per 2N+1 cycles.
- x is updated element by element during SOLVE.
  - Intermediate values are visible but only meaningful while out_valid=1.
  - x holds its final value after out_valid falls, until the next SOLVE overwrites it.
- in_valid while in_ready=0 is ignored: no capture, no error, and the current solve is unaffected.
- Mid-operation input changes have no effect, because only the captured copies are used.
- A zero pivot never produces inf/NaN; the division is skipped.
- rst_n low at any point, including mid-PROJ or mid-SOLVE: immediate return to reset values, and no out_valid for the aborted solve.
- M > N: all M rows of Q and b contribute to y; R is still NxN.

Test Plan:
- Identity Q (M=N=3), R=[[2,1,1],[0,3,2],[0,0,4]], b=[5,7,8], in_valid at edge 0 -> out_valid exactly after edge 6, x=[1.0,1.0,2.0] within 1e-9, singular=0, in_ready low on edges 1–5.
- Q=[[0,1,0],[1,0,0],[0,0,1]], same R, b=[7,5,8] -> y=[5,7,8], x=[1.0,1.0,2.0], singular=0.
- Same R with R[2][2]=0.0, identity Q, b=[5,7,8] -> x[2]=0.0, x[1]=7/3, x[0]=(5−7/3)/2=1.3333333333, singular=1, no NaN/inf.
- Chain from the QR stage: A=[[1,2,3],[4,5,6],[7,8,9]], b=A·[1,0,0]=[1,4,7] -> the rank-deficient pivot sets singular=1. A second case, A=[[2,1,1],[1,3,2],[1,0,0]] with b=A·[1,2,3]=[7,13,1], gives x=[1,2,3] within 1e-6 and singular=0.
- Second in_valid pulses at edges 2 and 6 with different data -> both ignored, first result unchanged. A pulse at edge 7 is accepted and its out_valid appears after edge 13.
- rst_n asserted low during SOLVE (e.g. edge 4) for 2 cycles -> out_valid never pulses for that solve, x=[0,0,0], singular=0, in_ready=1. A subsequent solve completes normally.
